d_latch_monitor: RTL and testbench
==================================

Name: d_latch_monitor

Overview:
- Clocked, synthesizable checker for the D-latch lab block; the observing end of the latch interface.
- Samples the latch stimulus (D_in, enable_in) and the latch output (q_in) each clock.
- Keeps a reference model of the latch and flags any cycle where the observed output disagrees with it.
- Reports state, mismatch pulses, a saturating error count and a sticky fault flag; used in lab benches and on-board debug.

Parameters:
- CHECK_DELAY, 1, settle cycles allowed between a model update and the q_in compare; legal range 0..4.
- CNT_W, 8, width of err_count_out.

Ports:
- clk_in  input  1  sampling clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- D_in  input  1  latch data stimulus, synchronous to clk_in.
- enable_in  input  1  latch enable stimulus; 1 = transparent.
- q_in  input  1  observed latch output.
- clear_in  input  1  synchronous clear of fault_out, err_count_out and state.
- check_valid_out  output  1  a compare was performed this cycle.
- mismatch_out  output  1  one-cycle pulse on a failed compare.
- fault_out  output  1  sticky; set by any mismatch.
- err_count_out  output  CNT_W  saturating mismatch count.
- state_out  output  2  00 UNKNOWN, 01 TRANSPARENT, 10 HOLD, 11 FAULT.

Behaviour:
- Reset (async, rst_n_in=0): every output is 0. state is UNKNOWN. Model value and known bit are 0. Delay pipeline is cleared to not-known.
- Sample stage: at edge k, D_in, enable_in and q_in are registered as d[k], en[k], q[k].
- Model: E[k] = en[k] ? d[k] : E[k-1].
- Known bit: K[k] = K[k-1] | en[k].
- Pipeline: E and K pass through a CHECK_DELAY-deep shift register. With CHECK_DELAY=0 the path is direct.
- Compare: q[k] is compared with E[k-CHECK_DELAY] only when K[k-CHECK_DELAY]=1. There is no compare while the model is unknown.
- Output timing: compare results (check_valid_out, mismatch_out, counter, fault) are registered at edge k+1. Total latency from stimulus sample to flag is 1 cycle (CHECK_DELAY=0) or CHECK_DELAY+1 cycles.
- Counter: err_count_out increments by 1 per mismatch and saturates at 2^CNT_W-1; no wrap.
- Fault: fault_out stays set until clear_in or reset.
- FSM transitions, evaluated at each edge from the registered sample:
  - UNKNOWN -> TRANSPARENT on en=1.
  - TRANSPARENT -> HOLD on en=0.
  - HOLD -> TRANSPARENT on en=1.
  - Any state -> FAULT on a mismatch.
  - FAULT -> UNKNOWN on clear_in only.
- In FAULT, checking continues: mismatches still pulse and still count.
- clear_in (synchronous) has priority over a same-cycle mismatch. Counter and fault go to 0, state to UNKNOWN, and that cycle's mismatch is discarded. The model value and pipeline are NOT cleared, so checking resumes immediately.
- Reset asserted mid-operation: everything clears at once. After release, no compare happens until enable has been seen high and CHECK_DELAY cycles have passed.
- Inputs are assumed synchronous to clk_in; no synchronizers are included.

Decomposition:
- Shared package (lab constants include): 2-bit state encodings ST_UNKNOWN, ST_TRANSP, ST_HOLD, ST_FAULT, and the CHECK_DELAY maximum of 4.
- One sub-module, latch_ref_model: registered reference latch plus known bit and the CHECK_DELAY pipeline. Outputs exp_q and exp_known.
- The top level holds the FSM, the compare, the counter and the fault logic.

Test Plan:
- Reset hold, then release with enable_in=0 and D_in toggling for 10 cycles -> state_out=00, check_valid_out=0, err_count_out=0 throughout.
- Correct latch connected (CHECK_DELAY=1), D toggling every cycle, enable toggling every 2 cycles, 50 cycles -> state alternates 01/10, mismatch_out never 1, err_count_out=0.
- q_in forced 0 while enable=1 and D=1 -> mismatch_out pulses CHECK_DELAY+1 cycles after the sample, fault_out=1, state_out=11, err_count_out=1.
- CNT_W=3, q_in held opposite to the model for 12 compares -> err_count_out reaches 7 and stays at 7.
- clear_in asserted in the same cycle as a mismatch -> next cycle err_count_out=0, fault_out=0, state_out=00. A correct q_in on the following cycles gives no new mismatch.
- rst_n_in pulsed low mid-stream for 3 ns (asynchronous to the clock) -> all outputs 0 immediately. No compare until enable=1 is sampled plus CHECK_DELAY cycles.

Source files
------------

// File: rtl/d_latch_monitor_pkg.sv
// Shared constants for the D-latch lab monitor: FSM state encodings and the
// largest supported compare delay.
package d_latch_monitor_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_TRANSP  = 2'b01,
        ST_HOLD    = 2'b10,
        ST_FAULT   = 2'b11
    } state_e;

    localparam int unsigned CHECK_DELAY_MAX = 4;

endpackage

// File: rtl/d_latch_monitor_latch_ref_model.sv
// Reference D-latch built from the registered stimulus, plus a known bit and a
// CHECK_DELAY-deep pipeline that lines the model up with the observed output.
module latch_ref_model
    import d_latch_monitor_pkg::*;
#(
    parameter int unsigned CHECK_DELAY = 1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_s,
    input  logic en_s,
    output logic exp_q,
    output logic exp_known
);

    localparam int unsigned DLY = (CHECK_DELAY > CHECK_DELAY_MAX) ? CHECK_DELAY_MAX : CHECK_DELAY;

    logic e_q;
    logic k_q;
    logic e_next;
    logic k_next;

    // Model value for the current sample; the register holds the previous one.
    always_comb begin
        e_next = en_s ? d_s : e_q;
        k_next = k_q | en_s;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            e_q <= 1'b0;
            k_q <= 1'b0;
        end else begin
            e_q <= e_next;
            k_q <= k_next;
        end
    end

    generate
        if (DLY == 0) begin : g_direct
            assign exp_q     = e_next;
            assign exp_known = k_next;
        end else begin : g_pipe
            logic [DLY-1:0] e_pipe;
            logic [DLY-1:0] k_pipe;
            logic [DLY:0]   e_shift;
            logic [DLY:0]   k_shift;

            assign e_shift = {e_pipe, e_next};
            assign k_shift = {k_pipe, k_next};

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    e_pipe <= '0;
                    k_pipe <= '0;
                end else begin
                    e_pipe <= e_shift[DLY-1:0];
                    k_pipe <= k_shift[DLY-1:0];
                end
            end

            assign exp_q     = e_pipe[DLY-1];
            assign exp_known = k_pipe[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/d_latch_monitor.sv
// Clocked checker for the D-latch lab block: compares the observed latch output
// against a reference model and reports state, mismatches, an error count and a fault.
module d_latch_monitor
    import d_latch_monitor_pkg::*;
#(
    parameter int unsigned CHECK_DELAY = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             D_in,
    input  logic             enable_in,
    input  logic             q_in,
    input  logic             clear_in,
    output logic             check_valid_out,
    output logic             mismatch_out,
    output logic             fault_out,
    output logic [CNT_W-1:0] err_count_out,
    output logic [1:0]       state_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic   d_s;
    logic   en_s;
    logic   q_s;
    logic   exp_q;
    logic   exp_known;
    logic   mis_c;
    state_e state_q;
    state_e state_d;

    // Sample stage
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            d_s  <= 1'b0;
            en_s <= 1'b0;
            q_s  <= 1'b0;
        end else begin
            d_s  <= D_in;
            en_s <= enable_in;
            q_s  <= q_in;
        end
    end

    latch_ref_model #(
        .CHECK_DELAY (CHECK_DELAY)
    ) u_ref (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .d_s       (d_s),
        .en_s      (en_s),
        .exp_q     (exp_q),
        .exp_known (exp_known)
    );

    assign mis_c = exp_known & (q_s ^ exp_q);

    // Next state: clear beats a mismatch, a mismatch beats enable tracking.
    always_comb begin
        state_d = state_q;
        if (clear_in) begin
            state_d = ST_UNKNOWN;
        end else if (mis_c) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_UNKNOWN: if (en_s)  state_d = ST_TRANSP;
                ST_TRANSP:  if (!en_s) state_d = ST_HOLD;
                ST_HOLD:    if (en_s)  state_d = ST_TRANSP;
                default:    state_d = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_UNKNOWN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_out = state_q;

    // Compare results, saturating counter and sticky fault.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            check_valid_out <= 1'b0;
            mismatch_out    <= 1'b0;
            fault_out       <= 1'b0;
            err_count_out   <= '0;
        end else begin
            check_valid_out <= exp_known;
            mismatch_out    <= mis_c & ~clear_in;
            if (clear_in) begin
                fault_out     <= 1'b0;
                err_count_out <= '0;
            end else if (mis_c) begin
                fault_out <= 1'b1;
                if (err_count_out != CNT_MAX) begin
                    err_count_out <= err_count_out + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_d_latch_monitor.sv
// Bench for d_latch_monitor: a hand-built vector table plus randomized stimulus
// checked against a per-cycle history model of the reference latch.
module tb_d_latch_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d, en, q, clr;
    logic       a_cv, a_mis, a_flt;
    logic [2:0] a_cnt;
    logic [1:0] a_st;
    logic       b_cv, b_mis, b_flt;
    logic [7:0] b_cnt;
    logic [1:0] b_st;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    d_latch_monitor #(.CHECK_DELAY(1), .CNT_W(3)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .D_in(d), .enable_in(en), .q_in(q),
        .clear_in(clr), .check_valid_out(a_cv), .mismatch_out(a_mis),
        .fault_out(a_flt), .err_count_out(a_cnt), .state_out(a_st)
    );

    d_latch_monitor #(.CHECK_DELAY(2), .CNT_W(8)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .D_in(d), .enable_in(en), .q_in(q),
        .clear_in(clr), .check_valid_out(b_cv), .mismatch_out(b_mis),
        .fault_out(b_flt), .err_count_out(b_cnt), .state_out(b_st)
    );

    // Behavioural model: E/K history per sample since reset, indexed by sample number.
    bit hE[$];
    bit hK[$];
    bit ps_d, ps_en, ps_q;
    int m_st[2], m_cnt[2];
    bit m_flt[2], m_cv[2], m_mis[2];
    int dly[2]  = '{1, 2};
    int cmax[2] = '{7, 255};

    typedef struct {
        bit d, en, q, clr;
        logic [1:0] st;
        bit cv, mis, flt;
        logic [2:0] cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hE.delete();
        hK.delete();
        ps_d = 0; ps_en = 0; ps_q = 0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_flt[i] = 0; m_cv[i] = 0; m_mis[i] = 0;
        end
    endtask

    function automatic bit pending_e();
        bit last = (hE.size() > 0) ? hE[$] : 1'b0;
        return ps_en ? ps_d : last;
    endfunction

    // Called right after a rising edge: resolves the previous sample, then latches the current inputs.
    task automatic model_edge(input bit clr_now);
        bit k_last = (hK.size() > 0) ? hK[$] : 1'b0;
        int j;
        hE.push_back(pending_e());
        hK.push_back(k_last | ps_en);
        j = hE.size() - 1;
        for (int i = 0; i < 2; i++) begin
            int idx = j - dly[i];
            bit kn = (idx >= 0) ? hK[idx] : 1'b0;
            bit ex = (idx >= 0) ? hE[idx] : 1'b0;
            bit mis = kn && (ps_q != ex);
            m_cv[i] = kn;
            if (clr_now) begin
                m_mis[i] = 0; m_cnt[i] = 0; m_flt[i] = 0; m_st[i] = 0;
            end else begin
                m_mis[i] = mis;
                if (mis) begin
                    m_flt[i] = 1;
                    m_st[i]  = 3;
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                end else if (m_st[i] == 3) begin
                    m_st[i] = 3;
                end else if (ps_en) begin
                    m_st[i] = 1;
                end else if (m_st[i] == 1) begin
                    m_st[i] = 2;
                end
            end
        end
        ps_d = d; ps_en = en; ps_q = q;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a.st"},  a_st,  m_st[0]);
        chk({tag, "/a.cv"},  a_cv,  m_cv[0]);
        chk({tag, "/a.mis"}, a_mis, m_mis[0]);
        chk({tag, "/a.flt"}, a_flt, m_flt[0]);
        chk({tag, "/a.cnt"}, a_cnt, m_cnt[0]);
        chk({tag, "/b.st"},  b_st,  m_st[1]);
        chk({tag, "/b.cv"},  b_cv,  m_cv[1]);
        chk({tag, "/b.mis"}, b_mis, m_mis[1]);
        chk({tag, "/b.flt"}, b_flt, m_flt[1]);
        chk({tag, "/b.cnt"}, b_cnt, m_cnt[1]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/a.out"}, {a_st, a_cv, a_mis, a_flt, a_cnt}, 0);
        chk({tag, "/b.out"}, {b_st, b_cv, b_mis, b_flt, b_cnt}, 0);
    endtask

    task automatic step(input bit di, input bit ei, input bit qi, input bit ci, input string tag);
        d = di; en = ei; q = qi; clr = ci;
        @(posedge clk);
        model_edge(ci);
        #1;
        check_all(tag);
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic void add(input bit di, ei, qi, ci, input logic [1:0] st,
                                input bit cv, mis, flt, input logic [2:0] cnt);
        vec_t v;
        v.d = di; v.en = ei; v.q = qi; v.clr = ci;
        v.st = st; v.cv = cv; v.mis = mis; v.flt = flt; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Expected dut_a (delay 1, 3-bit counter) outputs after each edge.
        add(1,0,0,0, 2'b00,0,0,0,0);
        add(0,0,0,0, 2'b00,0,0,0,0);
        add(1,1,0,0, 2'b00,0,0,0,0);
        add(1,1,1,0, 2'b01,0,0,0,0);
        add(1,1,1,0, 2'b01,1,0,0,0);
        add(0,0,1,0, 2'b01,1,0,0,0);
        add(0,0,1,0, 2'b10,1,0,0,0);
        add(0,0,0,0, 2'b10,1,0,0,0);
        add(0,0,1,0, 2'b11,1,1,1,1);
        add(0,1,1,0, 2'b11,1,0,1,1);
        add(0,1,1,0, 2'b11,1,0,1,1);
        add(0,0,0,1, 2'b00,1,0,0,0);
        add(0,0,0,0, 2'b00,1,0,0,0);
        add(1,1,0,0, 2'b00,1,0,0,0);
        add(1,1,1,0, 2'b01,1,0,0,0);
        add(1,1,1,0, 2'b01,1,0,0,0);
        add(1,1,0,0, 2'b01,1,0,0,0);
        for (int n = 17; n < 30; n++) begin
            add(1,1,0,0, 2'b11,1,1,1, (n - 16 > 7) ? 3'd7 : 3'(n - 16));
        end

        rst_n = 1'b0; d = 0; en = 0; q = 0; clr = 0;
        model_reset();
        #12;
        check_zero("reset");
        #5;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            string t = $sformatf("tv%0d", i);
            step(tbl[i].d, tbl[i].en, tbl[i].q, tbl[i].clr, t);
            chk({t, "/st"},  a_st,  tbl[i].st);
            chk({t, "/cv"},  a_cv,  tbl[i].cv);
            chk({t, "/mis"}, a_mis, tbl[i].mis);
            chk({t, "/flt"}, a_flt, tbl[i].flt);
            chk({t, "/cnt"}, a_cnt, tbl[i].cnt);
        end

        rst_pulse("rst1");
        for (int i = 0; i < 10; i++) begin
            step(bit'(i % 2), 1'b0, 1'($urandom_range(1)), 1'b0, "idle");
            chk("idle/a.st", a_st, 0);
            chk("idle/a.cv", a_cv, 0);
        end

        // Correct latch output for the delay-1 instance.
        for (int i = 0; i < 50; i++) begin
            bit di = bit'(i % 2);
            bit ei = ((i / 2) % 2) == 0;
            step(di, ei, pending_e(), 1'b0, "latch50");
        end
        chk("latch50/a.cnt", a_cnt, 0);
        chk("latch50/a.flt", a_flt, 0);

        for (int i = 0; i < 300; i++) begin
            bit ei = $urandom_range(2) != 0;
            bit di = 1'($urandom_range(1));
            bit qi = pending_e() ^ ($urandom_range(9) == 0);
            bit ci = $urandom_range(19) == 0;
            if (i == 150) rst_pulse("rst2");
            step(di, ei, qi, ci, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
